// File: rtl/core_mem_responder.sv
// Memory-side responder for core load/store requests: word-addressed SRAM model
// answering each accepted request after a fixed, programmable latency.
module core_mem_responder #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e        state_q;
    logic [3:0]    cnt_q;
    logic          rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_error_q;
    logic [31:0]   mem [DEPTH];

    logic          req_err;
    logic          accept;
    logic [AW-1:0] word_idx;

    // Range check uses the full 30-bit word index so high addresses never alias.
    assign req_err   = (req_addr[1:0] != 2'b00) || (32'(req_addr[31:2]) >= DEPTH);
    assign word_idx  = req_addr[AW+1:2];
    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_error = rsp_error_q;

    // Backing store is deliberately not reset; contents survive rst.
    always_ff @(posedge clk) begin
        if (accept && req_wen && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_error_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        rsp_error_q <= req_err;
                        // Read data is captured here so later writes cannot affect it.
                        rsp_rdata_q <= (req_err || req_wen) ? 32'h0 : mem[word_idx];
                        if (LATENCY == 1) begin
                            state_q     <= StResp;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            cnt_q   <= 4'(LATENCY - 1);
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_q     <= StResp;
                        rsp_valid_q <= 1'b1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q     <= StIdle;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_error_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_core_mem_responder.sv
// Scoreboard bench for core_mem_responder: a LATENCY=2 instance checked through an
// expected-response queue, plus LATENCY=1 and LATENCY=15 instances for latency timing.
module tb_core_mem_responder;

    localparam int MainLat = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_error;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    logic [1:0]  x_req_valid, x_req_ready, x_req_wen, x_rsp_valid, x_rsp_error;
    logic [31:0] x_req_addr [2];
    logic [31:0] x_req_wdata [2];
    logic [31:0] x_rsp_rdata [2];
    logic [3:0]  x_req_wstrb [2];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    core_mem_responder #(.DEPTH(1024), .LATENCY(MainLat)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_error(rsp_error)
    );

    core_mem_responder #(.DEPTH(1024), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .req_valid(x_req_valid[0]), .req_ready(x_req_ready[0]), .req_addr(x_req_addr[0]),
        .req_wen(x_req_wen[0]), .req_wdata(x_req_wdata[0]), .req_wstrb(x_req_wstrb[0]),
        .rsp_valid(x_rsp_valid[0]), .rsp_ready(1'b1), .rsp_rdata(x_rsp_rdata[0]),
        .rsp_error(x_rsp_error[0])
    );

    core_mem_responder #(.DEPTH(1024), .LATENCY(15)) u_dut_l15 (
        .clk(clk), .rst(rst),
        .req_valid(x_req_valid[1]), .req_ready(x_req_ready[1]), .req_addr(x_req_addr[1]),
        .req_wen(x_req_wen[1]), .req_wdata(x_req_wdata[1]), .req_wstrb(x_req_wstrb[1]),
        .rsp_valid(x_rsp_valid[1]), .rsp_ready(1'b1), .rsp_rdata(x_rsp_rdata[1]),
        .rsp_error(x_rsp_error[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every cycle a response is presented it must match the queue head.
    always @(negedge clk) begin
        if (!rst && rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 32'(exp_q.size()), 32'd1);
            end else begin
                if (!prev_valid) check("rsp_latency_cycle", cyc, exp_q[0].cyc);
                check("rsp_rdata", rsp_rdata, exp_q[0].rdata);
                check("rsp_error", 32'(rsp_error), 32'(exp_q[0].err));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
        prev_valid = rsp_valid;
    end

    task automatic issue(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input logic [3:0] s, input logic [31:0] er, input logic ee,
                         input bit push);
        bit ok = 1'b0;
        req_addr  = a;
        req_wen   = w;
        req_wdata = d;
        req_wstrb = s;
        req_valid = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
        end
        if (!ok) begin
            check("req_accept_timeout", 32'(ok), 32'd1);
            req_valid = 1'b0;
            return;
        end
        if (push) exp_q.push_back('{er, ee, cyc + MainLat});
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic rw(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] er, input logic ee);
        issue(a, w, d, s, er, ee, 1'b1);
        drain();
    endtask

    task automatic lat_test(input int g, input int lat, input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic [31:0] er);
        bit ok = 1'b0;
        int n;
        x_req_addr[g]  = a;
        x_req_wen[g]   = w;
        x_req_wdata[g] = d;
        x_req_wstrb[g] = 4'hF;
        x_req_valid[g] = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (x_req_ready[g]) ok = 1'b1;
        end
        check("x_req_accept", 32'(ok), 32'd1);
        n = cyc;
        @(posedge clk);
        #1 x_req_valid[g] = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (x_rsp_valid[g]) ok = 1'b1;
        end
        check("x_latency", 32'(cyc - n), 32'(lat));
        check("x_rdata", x_rsp_rdata[g], er);
        check("x_error", 32'(x_rsp_error[g]), 32'd0);
        @(negedge clk);
        check("x_ready_after_rsp", 32'(x_req_ready[g]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        rsp_ready = 1'b1;
        x_req_valid = '0; x_req_wen = '0;
        for (int g = 0; g < 2; g++) begin
            x_req_addr[g] = '0; x_req_wdata[g] = '0; x_req_wstrb[g] = '0;
        end

        // Reset state
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_x_req_ready", 32'(x_req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;

        // Basic write/read
        rw(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
        rw(32'h10, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Byte strobes and empty strobe
        rw(32'h20, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0);
        rw(32'h20, 1'b1, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
        rw(32'h20, 1'b0, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
        rw(32'h20, 1'b1, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
        rw(32'h20, 1'b0, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

        // Errors and range boundary
        rw(32'h0, 1'b1, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        rw(32'hFFC, 1'b1, 32'h600DCAFE, 4'hF, 32'h0, 1'b0);
        rw(32'h2, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        rw(32'h1000, 1'b1, 32'h12345678, 4'hF, 32'h0, 1'b1);
        rw(32'h13, 1'b1, 32'h87654321, 4'hF, 32'h0, 1'b1);
        rw(32'h80000000, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
        rw(32'h0, 1'b0, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
        rw(32'hFFC, 1'b0, 32'h0, 4'h0, 32'h600DCAFE, 1'b0);
        rw(32'h10, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Backpressure with a competing request held on the request channel
        rsp_ready = 1'b0;
        issue(32'h10, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        req_addr = 32'h10; req_wen = 1'b1; req_wdata = 32'hFFFFFFFF; req_wstrb = 4'hF;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (rsp_valid) ok = 1'b1;
        end
        check("bp_rsp_seen", 32'(ok), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_req_ready_after", 32'(req_ready), 32'd1);
        check("bp_rsp_valid_after", 32'(rsp_valid), 32'd0);
        drain();
        @(posedge clk);
        #1;
        rw(32'h10, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);

        // Mid-flight reset: committed write stays, response dropped
        rw(32'h40, 1'b1, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0);
        issue(32'h44, 1'b1, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
            check("post_mid_rst_req_ready", 32'(req_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        rw(32'h44, 1'b0, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0);
        rw(32'h40, 1'b0, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0);

        // Latency extremes
        lat_test(0, 1, 32'h8, 1'b1, 32'h01020304, 32'h0);
        lat_test(0, 1, 32'h8, 1'b0, 32'h0, 32'h01020304);
        lat_test(1, 15, 32'hC, 1'b1, 32'hA5A5F00F, 32'h0);
        lat_test(1, 15, 32'hC, 1'b0, 32'h0, 32'hA5A5F00F);

        check("queue_empty_at_end", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
